// File: rtl/mem_pkg.sv
// Shared definitions for the port-B memory arbiter: default widths,
// arbiter FSM state encoding and requester identifiers.
package mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    ARB_S  = 1'b0,
    LOCK_S = 1'b1
  } arb_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/mem_b_arbiter_if.sv
// Bundle of the CPU/loader request buses and the memory port-B wires.
// Optional macro ARB_STATS_EN adds the statistics clear/counter signals.
interface mem_b_arbiter_if import mem_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic              dma_req;
  logic              dma_lock;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr_b;
  logic              mem_we_b;
  logic [DATA_W-1:0] mem_wdata_b;
  logic [DATA_W-1:0] mem_rdata_b;
`ifdef ARB_STATS_EN
  logic              stat_clr;
  logic [15:0]       stat_conflict;
  logic [15:0]       stat_cpu_stall;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_lock, dma_we, dma_addr, dma_wdata, mem_rdata_b, stat_clr,
    output cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, rdata,
    output mem_addr_b, mem_we_b, mem_wdata_b, stat_conflict, stat_cpu_stall
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_lock, dma_we, dma_addr, dma_wdata, mem_rdata_b, stat_clr,
    input  cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, rdata,
    input  mem_addr_b, mem_we_b, mem_wdata_b, stat_conflict, stat_cpu_stall
  );
`else
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_lock, dma_we, dma_addr, dma_wdata, mem_rdata_b,
    output cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, rdata,
    output mem_addr_b, mem_we_b, mem_wdata_b
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_lock, dma_we, dma_addr, dma_wdata, mem_rdata_b,
    input  cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, rdata,
    input  mem_addr_b, mem_we_b, mem_wdata_b
  );
`endif
endinterface

// File: rtl/mem_b_arbiter_rr_arb2.sv
// Two-way round-robin grant with a last-winner register; force_i hands
// the slot to the loader unconditionally while a burst lock holds.
module rr_arb2 import mem_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       force_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= REQ_DMA;
    else      last_q <= last_d;
  end

  always_comb begin
    gnt_o = 2'b00;
    if (force_i) begin
      gnt_o[REQ_DMA] = req_i[REQ_DMA];
    end else if (&req_i) begin
      if (last_q == REQ_DMA) gnt_o[REQ_CPU] = 1'b1;
      else                   gnt_o[REQ_DMA] = 1'b1;
    end else begin
      gnt_o = req_i;
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt_o[REQ_DMA])      last_d = REQ_DMA;
    else if (gnt_o[REQ_CPU]) last_d = REQ_CPU;
  end

endmodule

// File: rtl/mem_b_arbiter.sv
// Port-B arbiter between CPU MEM stage and loader: round-robin with bounded
// loader burst lock, 1-cycle read-valid pipeline. Optional: ARB_STATS_EN.
module mem_b_arbiter import mem_pkg::*; #(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_LOCK = 16
) (
  input  logic            clk,
  input  logic            rst,
  mem_b_arbiter_if.slave  bus
);

  localparam int                CNT_W   = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_LOCK);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             lock_cont;
  logic [1:0]       gnt;
  logic             cpu_rvalid_q, dma_rvalid_q;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == MAX_CNT) ? v : v + 1'b1;
  endfunction

  // Lock survives only while the loader keeps asking for it and the CPU has
  // not yet waited out MAX_LOCK locked grants; otherwise decide as ARB.
  assign lock_cont = (state_q == LOCK_S) & bus.dma_req & bus.dma_lock &
                     ~(bus.cpu_req & (lock_cnt_q == MAX_CNT));

  rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req_i   ({bus.dma_req, bus.cpu_req}),
    .force_i (lock_cont),
    .gnt_o   (gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_S;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  always_comb begin
    state_d    = ARB_S;
    lock_cnt_d = '0;
    if (lock_cont) begin
      state_d    = LOCK_S;
      lock_cnt_d = bus.cpu_req ? sat_inc_cnt(lock_cnt_q) : lock_cnt_q;
    end else if (gnt[REQ_DMA] & bus.dma_lock) begin
      state_d    = LOCK_S;
      lock_cnt_d = CNT_W'(1);
    end
  end

  always_comb begin
    bus.cpu_gnt     = gnt[REQ_CPU];
    bus.dma_gnt     = gnt[REQ_DMA];
    bus.cpu_stall   = bus.cpu_req & ~gnt[REQ_CPU];
    bus.mem_we_b    = 1'b0;
    bus.mem_addr_b  = '0;
    bus.mem_wdata_b = '0;
    if (gnt[REQ_CPU]) begin
      bus.mem_we_b    = bus.cpu_we;
      bus.mem_addr_b  = bus.cpu_addr;
      bus.mem_wdata_b = bus.cpu_wdata;
    end else if (gnt[REQ_DMA]) begin
      bus.mem_we_b    = bus.dma_we;
      bus.mem_addr_b  = bus.dma_addr;
      bus.mem_wdata_b = bus.dma_wdata;
    end
  end

  // Read-valid stage aligned with the memory's synchronous read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
    end else begin
      cpu_rvalid_q <= gnt[REQ_CPU] & ~bus.cpu_we;
      dma_rvalid_q <= gnt[REQ_DMA] & ~bus.dma_we;
    end
  end

  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.dma_rvalid = dma_rvalid_q;
  assign bus.rdata      = bus.mem_rdata_b;

`ifdef ARB_STATS_EN
  logic [15:0] stat_conflict_q, stat_cpu_stall_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_conflict_q  <= '0;
      stat_cpu_stall_q <= '0;
    end else if (bus.stat_clr) begin
      stat_conflict_q  <= '0;
      stat_cpu_stall_q <= '0;
    end else begin
      if (bus.cpu_req & bus.dma_req) stat_conflict_q  <= sat_inc16(stat_conflict_q);
      if (bus.cpu_stall)             stat_cpu_stall_q <= sat_inc16(stat_cpu_stall_q);
    end
  end

  assign bus.stat_conflict  = stat_conflict_q;
  assign bus.stat_cpu_stall = stat_cpu_stall_q;
`endif

endmodule

// File: tb/tb_mem_b_arbiter.sv
// Bench for mem_b_arbiter: directed scenarios with literal expectations,
// then randomized level-held traffic against a behavioural model.
module tb_mem_b_arbiter;
  import mem_pkg::*;

  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int MAXL = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_b_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_b_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(MAXL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 8'hA5 : (a ^ 8'h3C);
  endfunction

  // Synchronous-read memory behind port B; unwritten cells hold init_val.
  logic [7:0]   mem [256];
  logic [255:0] wr_flag = '0;
  always @(posedge clk) begin
    if (bus.mem_we_b) begin
      mem[bus.mem_addr_b]     <= bus.mem_wdata_b;
      wr_flag[bus.mem_addr_b] <= 1'b1;
    end
    bus.mem_rdata_b <= wr_flag[bus.mem_addr_b] ? mem[bus.mem_addr_b] : init_val(bus.mem_addr_b);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who should win this cycle, given the lock run length.
  initial begin : model
    bit         mlast, mlocked, cont, ec, ed, ncrv, ndrv, ewe;
    bit         exp_crv, exp_drv;
    int         mrun;
    logic [7:0] exp_rd, nrd, ea, ew;
    logic [7:0] shadow [256];
    for (int i = 0; i < 256; i++) shadow[i] = init_val(8'(i));
    mlast = 1'b1; mlocked = 1'b0; mrun = 0;
    exp_crv = 1'b0; exp_drv = 1'b0; exp_rd = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mlast = 1'b1; mlocked = 1'b0; mrun = 0;
        exp_crv = 1'b0; exp_drv = 1'b0;
      end
      cont = mlocked && bus.dma_req && bus.dma_lock && !(bus.cpu_req && mrun >= MAXL);
      if (cont) begin
        ec = 1'b0; ed = 1'b1;
      end else if (bus.cpu_req && bus.dma_req) begin
        ec = mlast; ed = !mlast;
      end else begin
        ec = bus.cpu_req; ed = bus.dma_req;
      end
      ewe = 1'b0; ea = '0; ew = '0;
      if (ec) begin
        ewe = bus.cpu_we; ea = bus.cpu_addr; ew = bus.cpu_wdata;
      end else if (ed) begin
        ewe = bus.dma_we; ea = bus.dma_addr; ew = bus.dma_wdata;
      end
      chk("m_cpu_gnt",   bus.cpu_gnt,     ec);
      chk("m_dma_gnt",   bus.dma_gnt,     ed);
      chk("m_cpu_stall", bus.cpu_stall,   bus.cpu_req && !ec);
      chk("m_we_b",      bus.mem_we_b,    ewe);
      chk("m_addr_b",    bus.mem_addr_b,  ea);
      chk("m_wdata_b",   bus.mem_wdata_b, ew);
      chk("m_cpu_rvalid", bus.cpu_rvalid, exp_crv);
      chk("m_dma_rvalid", bus.dma_rvalid, exp_drv);
      if (exp_crv || exp_drv) chk("m_rdata", bus.rdata, exp_rd);
      ncrv = ec && !bus.cpu_we;
      ndrv = ed && !bus.dma_we;
      nrd  = shadow[ea];
      if (ewe) shadow[ea] = ew;
      if (rst) begin
        if (ec) begin
          mlast = 1'b0; mlocked = 1'b0; mrun = 0;
        end else if (ed) begin
          mlast = 1'b1;
          if (cont) begin
            if (bus.cpu_req && mrun < MAXL) mrun++;
          end else if (bus.dma_lock) begin
            mlocked = 1'b1; mrun = 1;
          end else begin
            mlocked = 1'b0; mrun = 0;
          end
        end else begin
          mlocked = 1'b0; mrun = 0;
        end
        exp_crv = ncrv; exp_drv = ndrv; exp_rd = nrd;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_lock = 1'b0; bus.dma_we = 1'b0;
    bus.dma_addr = '0; bus.dma_wdata = '0;
  endtask

  task automatic cpu_drv(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
    bus.cpu_req = r; bus.cpu_we = w; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic dma_drv(input logic r, input logic l, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
    bus.dma_req = r; bus.dma_lock = l; bus.dma_we = w; bus.dma_addr = a; bus.dma_wdata = d;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 1'b0);
    chk("rst_dma_rvalid", bus.dma_rvalid, 1'b0);
    cyc();
    rst = 1'b1;
  endtask

  initial begin : stim
    logic cg, dg;
    logic [3:0] exp_c, exp_d;
    logic [4:0] exp_c4, exp_d4;
    idle();
`ifdef ARB_STATS_EN
    bus.stat_clr = 1'b0;
`endif
    cyc(); cyc();
    rst = 1'b1;
    cyc();

    // CPU-only read of 0x10
    cpu_drv(1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    chk("t1_cpu_gnt", bus.cpu_gnt, 1'b1);
    chk("t1_addr_b", bus.mem_addr_b, 8'h10);
    cyc(); idle();
    @(negedge clk);
    chk("t1_cpu_rvalid", bus.cpu_rvalid, 1'b1);
    chk("t1_rdata", bus.rdata, 8'hA5);
    chk("t1_dma_rvalid", bus.dma_rvalid, 1'b0);
    cyc();

    // Simultaneous requests after reset: C, D, C, D
    do_reset();
    exp_c = 4'b0101; exp_d = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cpu_drv(1'b1, 1'b0, 8'h01, 8'h00);
      dma_drv(1'b1, 1'b0, 1'b0, 8'h02, 8'h00);
      @(negedge clk);
      chk("t2_cpu_gnt", bus.cpu_gnt, exp_c[i]);
      chk("t2_dma_gnt", bus.dma_gnt, exp_d[i]);
      chk("t2_cpu_stall", bus.cpu_stall, exp_d[i]);
      cyc();
    end
    idle(); cyc();

    // Loader locked write burst
    for (int i = 0; i < 6; i++) begin
      dma_drv(1'b1, 1'b1, 1'b1, 8'(8'h20 + i), 8'(i));
      @(negedge clk);
      chk("t3_dma_gnt", bus.dma_gnt, 1'b1);
      chk("t3_dma_rvalid", bus.dma_rvalid, 1'b0);
      cyc();
    end
    idle();
    @(negedge clk);
    for (int i = 0; i < 6; i++) chk("t3_mem", mem[8'(8'h20 + i)], 32'(i));
    chk("t3_rvalid_after", bus.dma_rvalid, 1'b0);
    cyc();

    // Lock starvation bound with MAX_LOCK=4: D D D D C D
    dma_drv(1'b1, 1'b1, 1'b0, 8'h30, 8'h00);
    @(negedge clk);
    chk("t4_dma_gnt_first", bus.dma_gnt, 1'b1);
    cyc();
    exp_c4 = 5'b01000; exp_d4 = 5'b10111;
    for (int i = 0; i < 5; i++) begin
      cpu_drv(1'b1, 1'b0, 8'h31, 8'h00);
      @(negedge clk);
      chk("t4_cpu_gnt", bus.cpu_gnt, exp_c4[i]);
      chk("t4_dma_gnt", bus.dma_gnt, exp_d4[i]);
      chk("t4_cpu_stall", bus.cpu_stall, exp_d4[i]);
      cyc();
    end
    idle(); cyc();

    // Reset in the cycle after a granted CPU read
    cpu_drv(1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    chk("t5_cpu_gnt", bus.cpu_gnt, 1'b1);
    cyc();
    idle();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_cpu_rvalid", bus.cpu_rvalid, 1'b0);
    cyc();
    rst = 1'b1;
    cpu_drv(1'b1, 1'b0, 8'h05, 8'h00);
    dma_drv(1'b1, 1'b0, 1'b0, 8'h06, 8'h00);
    @(negedge clk);
    chk("t5_first_conflict_cpu", bus.cpu_gnt, 1'b1);
    chk("t5_first_conflict_dma", bus.dma_gnt, 1'b0);
    cyc(); idle(); cyc();

`ifdef ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cpu_drv(1'b1, 1'b0, 8'h07, 8'h00);
      dma_drv(1'b1, 1'b0, 1'b0, 8'h08, 8'h00);
      cyc();
    end
    idle();
    @(negedge clk);
    chk("st_conflict", bus.stat_conflict, 16'd3);
    chk("st_cpu_stall", bus.stat_cpu_stall, 16'd1);
    cyc();
    bus.stat_clr = 1'b1;
    cyc();
    bus.stat_clr = 1'b0;
    @(negedge clk);
    chk("st_conflict_clr", bus.stat_conflict, 16'd0);
    chk("st_cpu_stall_clr", bus.stat_cpu_stall, 16'd0);
    cyc();
`endif

    // Randomized level-held traffic
    cg = 1'b0; dg = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!(bus.cpu_req && !cg))
        cpu_drv($urandom_range(0, 2) != 0, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
      if (!(bus.dma_req && !dg)) begin
        bus.dma_req   = $urandom_range(0, 3) != 0;
        bus.dma_we    = 1'($urandom);
        bus.dma_addr  = 8'($urandom_range(0, 15));
        bus.dma_wdata = 8'($urandom);
        if ($urandom_range(0, 7) == 0) bus.dma_lock = 1'($urandom);
      end
      @(negedge clk);
      cg = bus.cpu_gnt;
      dg = bus.dma_gnt;
      cyc();
    end
    idle(); cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
